// File: rtl/layer_compositor.sv
// N-channel priority pixel compositor with per-frame blade collision capture.
// Two-stage pipeline; hit results handed to game logic via valid/ack.
`timescale 1ns/1ps
module layer_compositor #(
    parameter int unsigned           CHANNELS    = 4,
    parameter int unsigned           COLOR_W     = 12,
    parameter logic [COLOR_W-1:0]    TRANSPARENT = '0
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          pix_valid,
    input  logic                          frame_end,
    input  logic [CHANNELS-1:0]           layer_en,
    input  logic [CHANNELS*COLOR_W-1:0]   layer_data,
    input  logic                          bg_en,
    input  logic [COLOR_W-1:0]            bg_data,
    output logic [COLOR_W-1:0]            pix_out,
    output logic                          pix_out_valid,
    output logic [CHANNELS-1:0]           hit_mask,
    output logic                          hit_valid,
    input  logic                          hit_ack,
    output logic                          hit_overrun
);

    // Stage 1 registers
    logic [CHANNELS-1:0]          op_q, op_d;
    logic [CHANNELS*COLOR_W-1:0]  data_q, data_d;
    logic                         bg_op_q, bg_op_d;
    logic [COLOR_W-1:0]           bg_data_q, bg_data_d;
    logic                         v1_q, v1_d;
    logic                         fe1_q, fe1_d;

    // Stage 2 / result registers
    logic [COLOR_W-1:0]           pix_out_q, pix_out_d;
    logic                         pix_out_valid_q, pix_out_valid_d;
    logic [CHANNELS-1:1]          acc_q, acc_d;
    logic [CHANNELS-1:0]          hit_mask_q, hit_mask_d;
    logic                         hit_valid_q, hit_valid_d;
    logic                         hit_overrun_q, hit_overrun_d;

    logic [CHANNELS-1:0]          onehot;
    logic [COLOR_W-1:0]           sel;
    logic [CHANNELS-1:1]          coll;
    logic [CHANNELS-1:1]          frame_hits;
    logic                         latch;
    logic                         ack_ok;

    always_comb begin
        op_d = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            op_d[i] = layer_en[i] && (layer_data[i*COLOR_W +: COLOR_W] != TRANSPARENT);
        end
        data_d    = layer_data;
        bg_op_d   = bg_en && (bg_data != TRANSPARENT);
        bg_data_d = bg_data;
        v1_d      = pix_valid;
        fe1_d     = frame_end & pix_valid;
    end

    // Isolate the lowest set opaque bit, then AND-OR select: flat encoder, no mux chain.
    always_comb begin
        onehot = op_q & ((~op_q) + CHANNELS'(1));
        sel    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            sel = sel | ({COLOR_W{onehot[i]}} & data_q[i*COLOR_W +: COLOR_W]);
        end
    end

    always_comb begin
        pix_out_d = TRANSPARENT;
        if (v1_q) begin
            if (|op_q) begin
                pix_out_d = sel;
            end else if (bg_op_q) begin
                pix_out_d = bg_data_q;
            end
        end
        pix_out_valid_d = v1_q;
    end

    always_comb begin
        coll = '0;
        for (int unsigned i = 1; i < CHANNELS; i++) begin
            coll[i] = v1_q & op_q[0] & op_q[i];
        end
        frame_hits = acc_q | coll;
        latch      = v1_q & fe1_q;
        ack_ok     = hit_ack & hit_valid_q;

        acc_d      = latch ? '0 : frame_hits;
        hit_mask_d = hit_mask_q;
        if (latch) begin
            hit_mask_d = {frame_hits, |frame_hits};
        end

        // A latch always wins over a same-cycle ack; overrun only when no ack came with it.
        hit_valid_d   = latch | (hit_valid_q & ~hit_ack);
        hit_overrun_d = hit_overrun_q;
        if (latch && hit_valid_q && !hit_ack) begin
            hit_overrun_d = 1'b1;
        end else if (ack_ok) begin
            hit_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q            <= '0;
            data_q          <= '0;
            bg_op_q         <= 1'b0;
            bg_data_q       <= '0;
            v1_q            <= 1'b0;
            fe1_q           <= 1'b0;
            pix_out_q       <= TRANSPARENT;
            pix_out_valid_q <= 1'b0;
            acc_q           <= '0;
            hit_mask_q      <= '0;
            hit_valid_q     <= 1'b0;
            hit_overrun_q   <= 1'b0;
        end else begin
            op_q            <= op_d;
            data_q          <= data_d;
            bg_op_q         <= bg_op_d;
            bg_data_q       <= bg_data_d;
            v1_q            <= v1_d;
            fe1_q           <= fe1_d;
            pix_out_q       <= pix_out_d;
            pix_out_valid_q <= pix_out_valid_d;
            acc_q           <= acc_d;
            hit_mask_q      <= hit_mask_d;
            hit_valid_q     <= hit_valid_d;
            hit_overrun_q   <= hit_overrun_d;
        end
    end

    assign pix_out       = pix_out_q;
    assign pix_out_valid = pix_out_valid_q;
    assign hit_mask      = hit_mask_q;
    assign hit_valid     = hit_valid_q;
    assign hit_overrun   = hit_overrun_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: priority table plus frame/handshake/reset/gap sequences.
`timescale 1ns/1ps
module tb_layer_compositor;

    logic        clk;
    logic        rstn;
    logic        pix_valid;
    logic        frame_end;
    logic [3:0]  layer_en;
    logic [47:0] layer_data;
    logic        bg_en;
    logic [11:0] bg_data;
    logic [11:0] pix_out;
    logic        pix_out_valid;
    logic [3:0]  hit_mask;
    logic        hit_valid;
    logic        hit_ack;
    logic        hit_overrun;

    int passed;
    int total;

    layer_compositor #(
        .CHANNELS    (4),
        .COLOR_W     (12),
        .TRANSPARENT (12'h000)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pix_valid     (pix_valid),
        .frame_end     (frame_end),
        .layer_en      (layer_en),
        .layer_data    (layer_data),
        .bg_en         (bg_en),
        .bg_data       (bg_data),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid),
        .hit_mask      (hit_mask),
        .hit_valid     (hit_valid),
        .hit_ack       (hit_ack),
        .hit_overrun   (hit_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [47:0] data;
        logic        bg_en;
        logic [11:0] bg;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic pv, input logic fe, input logic [3:0] en,
                         input logic [47:0] d, input logic be, input logic [11:0] bd);
        pix_valid  = pv;
        frame_end  = fe;
        layer_en   = en;
        layer_data = d;
        bg_en      = be;
        bg_data    = bd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'b0000, 48'h0, 1'b0, 12'h000);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pix_out"},  32'(pix_out), 32'h000);
        check({tag, "_pov"},      32'(pix_out_valid), 32'h0);
        check({tag, "_hit_mask"}, 32'(hit_mask), 32'h0);
        check({tag, "_hit_valid"},32'(hit_valid), 32'h0);
        check({tag, "_overrun"},  32'(hit_overrun), 32'h0);
    endtask

    task automatic do_ack();
        hit_ack = 1'b1;
        tick();
        hit_ack = 1'b0;
    endtask

    logic        gap_pv  [8];
    logic [11:0] gap_col [8];

    initial begin
        passed  = 0;
        total   = 0;
        rstn    = 1'b0;
        hit_ack = 1'b0;
        idle();

        // Layer data packed as {L3, L2, L1, L0}
        vecs[0] = '{4'b1010, {12'h00F, 12'h000, 12'h0F0, 12'h000}, 1'b1, 12'hFFF, 12'h0F0};
        vecs[1] = '{4'b1000, {12'h00F, 12'h000, 12'h0F0, 12'h000}, 1'b1, 12'hFFF, 12'h00F};
        vecs[2] = '{4'b0000, {12'h00F, 12'h000, 12'h0F0, 12'h000}, 1'b1, 12'hFFF, 12'hFFF};
        vecs[3] = '{4'b0000, {12'h00F, 12'h000, 12'h0F0, 12'h000}, 1'b0, 12'hFFF, 12'h000};
        vecs[4] = '{4'b0101, {12'h000, 12'h123, 12'h000, 12'h000}, 1'b1, 12'hFFF, 12'h123};
        vecs[5] = '{4'b0000, {12'hABC, 12'hABC, 12'hABC, 12'hABC}, 1'b1, 12'h000, 12'h000};
        vecs[6] = '{4'b1100, {12'h00F, 12'h123, 12'h0F0, 12'hF00}, 1'b1, 12'hFFF, 12'h123};
        vecs[7] = '{4'b1111, {12'h00F, 12'h123, 12'h0F0, 12'hF00}, 1'b1, 12'hFFF, 12'hF00};

        tick();
        tick();
        check_reset_state("init_reset");
        rstn = 1'b1;

        // Priority table: hold each vector two cycles so it fills the pipeline.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, vecs[i].en, vecs[i].data, vecs[i].bg_en, vecs[i].bg);
            tick();
            tick();
            check($sformatf("vec%0d_pix", i), 32'(pix_out), 32'(vecs[i].exp));
            check($sformatf("vec%0d_pov", i), 32'(pix_out_valid), 32'h1);
        end

        // Reset with a live pipeline (last vector still streaming).
        rstn = 1'b0;
        tick();
        check_reset_state("reset_live");
        rstn = 1'b1;
        idle();
        tick();

        // Transparent channel 0 plus opaque channel 2 ends a frame: no hit.
        drive(1'b1, 1'b1, 4'b0101, {12'h000, 12'h123, 12'h000, 12'h000}, 1'b0, 12'h000);
        tick();
        idle();
        tick();
        check("transp_pix", 32'(pix_out), 32'h123);
        check("transp_hit_valid", 32'(hit_valid), 32'h1);
        check("transp_hit_mask", 32'(hit_mask), 32'h0);
        do_ack();
        check("transp_ack_valid", 32'(hit_valid), 32'h0);

        // Frame hits: ch0+ch2 overlap on pixel 4 only; ch0 alone on pixel 6, ch1 alone on pixel 1.
        for (int p = 0; p < 10; p++) begin
            logic [3:0] en;
            en = 4'b0000;
            if (p == 4) en = 4'b0101;
            if (p == 6) en = 4'b0001;
            if (p == 1) en = 4'b0010;
            drive(1'b1, (p == 9), en, {12'h444, 12'h333, 12'h222, 12'h111}, 1'b1, 12'hFFF);
            tick();
        end
        check("frame1_not_yet", 32'(hit_valid), 32'h0);
        idle();
        tick();
        check("frame1_hit_valid", 32'(hit_valid), 32'h1);
        check("frame1_hit_mask", 32'(hit_mask), 32'h5);
        check("frame1_overrun", 32'(hit_overrun), 32'h0);
        tick();
        check("frame1_valid_holds", 32'(hit_valid), 32'h1);
        do_ack();
        check("frame1_ack_valid", 32'(hit_valid), 32'h0);
        check("frame1_mask_holds", 32'(hit_mask), 32'h5);

        // Second frame without blade overlap still reports.
        for (int p = 0; p < 5; p++) begin
            drive(1'b1, (p == 4), 4'b1010, {12'h444, 12'h333, 12'h222, 12'h111}, 1'b1, 12'hFFF);
            tick();
        end
        idle();
        tick();
        check("frame2_hit_valid", 32'(hit_valid), 32'h1);
        check("frame2_hit_mask", 32'(hit_mask), 32'h0);

        // Ack in the same cycle as a new latch: latch wins, no overrun.
        drive(1'b1, 1'b1, 4'b1001, {12'h444, 12'h333, 12'h222, 12'h111}, 1'b1, 12'hFFF);
        tick();
        idle();
        do_ack();
        check("same_cyc_valid", 32'(hit_valid), 32'h1);
        check("same_cyc_mask", 32'(hit_mask), 32'h9);
        check("same_cyc_overrun", 32'(hit_overrun), 32'h0);

        // Second latch without an ack: overrun.
        drive(1'b1, 1'b1, 4'b0011, {12'h444, 12'h333, 12'h222, 12'h111}, 1'b1, 12'hFFF);
        tick();
        idle();
        tick();
        check("overrun_valid", 32'(hit_valid), 32'h1);
        check("overrun_mask", 32'(hit_mask), 32'h3);
        check("overrun_flag", 32'(hit_overrun), 32'h1);
        do_ack();
        check("overrun_ack_valid", 32'(hit_valid), 32'h0);
        check("overrun_ack_flag", 32'(hit_overrun), 32'h0);
        do_ack();
        check("idle_ack_valid", 32'(hit_valid), 32'h0);
        check("idle_ack_mask", 32'(hit_mask), 32'h3);

        // Reset mid-frame discards the overlap seen before it.
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 1'b0, (p == 2) ? 4'b0011 : 4'b0000,
                  {12'h444, 12'h333, 12'h222, 12'h111}, 1'b1, 12'hFFF);
            tick();
        end
        rstn = 1'b0;
        tick();
        check_reset_state("reset_mid");
        rstn = 1'b1;
        for (int p = 3; p < 6; p++) begin
            drive(1'b1, (p == 5), 4'b0100, {12'h444, 12'h333, 12'h222, 12'h111}, 1'b1, 12'hFFF);
            tick();
        end
        idle();
        tick();
        check("reset_frame_valid", 32'(hit_valid), 32'h1);
        check("reset_frame_mask", 32'(hit_mask), 32'h0);
        do_ack();

        // Gaps: pix_valid toggles, frame_end on an invalid cycle, streaming latency of two.
        for (int k = 0; k < 8; k++) begin
            gap_pv[k]  = ((k % 2) == 0);
            gap_col[k] = 12'(12'h100 + k);
            drive(gap_pv[k], (k == 3), 4'b0011, {12'h000, 12'h000, gap_col[k], 12'hF0F},
                  1'b1, 12'hFFF);
            // Channel 0 is opaque and wins priority
            gap_col[k] = 12'hF0F;
            tick();
            if (k >= 1) begin
                check($sformatf("gap%0d_pov", k), 32'(pix_out_valid), 32'(gap_pv[k-1]));
                check($sformatf("gap%0d_pix", k), 32'(pix_out),
                      gap_pv[k-1] ? 32'(gap_col[k-1]) : 32'h000);
            end
        end
        idle();
        tick();
        tick();
        check("gap_no_latch", 32'(hit_valid), 32'h0);
        check("gap_pov_idle", 32'(pix_out_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
